// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO for any DEPTH >= 2, with standard or first-word-fall-through reads,
// an occupancy count, programmable almost flags and registered overflow/underflow pulses.
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 5,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

  // A full FIFO still takes a push when a pop frees the head in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap by compare so non-power-of-two depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overflow  <= push & ~push_ok;
      underflow <= pop & ~pop_ok;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= pop_ok;
          if (pop_ok) rd_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Synchronous single-clock FIFO, the parametrised successor of the power-of-two ring FIFO. It supports any depth ≥ 2 (not only powers of two) and selectable standard or first-word-fall-through (FWFT) read mode. It adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow protection with error pulses. It sits between producer and consumer blocks in the same clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥ 1)
- DEPTH, 5, number of storage entries; any integer ≥ 2
- FWFT, 0, 0 = standard read (data one cycle after pop); 1 = first-word-fall-through
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- push  in  1  write request
- pop  in  1  read request
- wr_data  in  WIDTH  write data, sampled on accepted push
- rd_data  out  WIDTH  read data (mode-dependent, see Operation)
- rd_valid  out  1  rd_data holds a valid word
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  one-cycle pulse: push rejected
- underflow  out  1  one-cycle pulse: pop rejected

## Operation
- Storage: DEPTH-entry array, not reset. wr_ptr and rd_ptr are each $clog2(DEPTH) bits wide. Each wraps from DEPTH-1 to 0 by explicit compare; natural binary overflow is not used.
- count register: +1 on accepted push only, −1 on accepted pop only, unchanged on both or neither. All flags decode combinationally from count.
- pop_ok = pop & ~empty.
- push_ok = push & (~full | pop_ok). When full, a push is accepted only together with an accepted pop; count stays at DEPTH.
- When empty, a push with a simultaneous pop: the push is accepted, the pop is rejected (underflow pulses).
- Rejected push: memory, wr_ptr and count unchanged; overflow = 1 next cycle for one cycle.
- Rejected pop: rd_ptr, count and rd_data unchanged; underflow = 1 next cycle for one cycle.
- FWFT=0: on pop_ok, rd_data <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1: rd_data = mem[rd_ptr] combinationally when ~empty, else all zeros. rd_valid = ~empty. pop_ok acknowledges the displayed word.
- Reset mid-operation: contents are discarded logically. Pointers, count and outputs return to reset values immediately; the next accepted push lands at entry 0.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0, wr_ptr=rd_ptr=0.
- Write to readable: a word pushed at edge N makes empty=0 after edge N.
  - FWFT=1: the word is visible on rd_data after edge N.
  - FWFT=0: pop at edge N+1 gives rd_data/rd_valid after edge N+1.
- Read latency: FWFT=0 is 1 cycle from pop to data; FWFT=1 is 0 cycles (the head is already presented).
- Flags update the cycle after the causing edge. There is no combinational path from push/pop to flags or count.
- overflow/underflow are registered, 1 cycle after the rejected request, 1 cycle wide. They repeat every cycle a rejection persists.
- Sustained push & pop every cycle at any fill level 1..DEPTH-1: throughput 1 word/cycle, count constant.

## Test plan
- Reset and fill, DEPTH=5, FWFT=0.
  - Stimulus: assert rst, release, push 0x11..0x55 on 5 consecutive cycles.
  - Required: count goes 1,2,3,4,5. almost_full first seen 1 at count=4. full=1 at count=5. empty=0 after the first push.
- Overflow and drain, non-pow2 wrap.
  - Stimulus: with FIFO full, push 0x66 for 2 cycles, then pop 5 times.
  - Required: overflow pulses 2 cycles, count stays 5. rd_data sequence is 0x11,0x22,0x33,0x44,0x55 with rd_valid each cycle. empty=1 at end.
  - Stimulus: push 3 more words.
  - Required: they land at ptr 0,1,2 (wrap from 4).
- Underflow and simultaneous access.
  - Stimulus: on empty FIFO, pop alone.
  - Required: underflow pulse, count 0.
  - Stimulus: push 0xA5 and pop in the same cycle.
  - Required: underflow pulse, count=1.
  - Stimulus: with FIFO full, push 0x77 and pop in the same cycle.
  - Required: no overflow, count stays 5, 0x77 read out last.
- FWFT=1 head presentation.
  - Stimulus: push 0x3C.
  - Required: the next cycle shows rd_valid=1 and rd_data=0x3C with no pop.
  - Stimulus: pop once.
  - Required: rd_valid=0 and rd_data=0 afterward.
- Thresholds.
  - Stimulus: AF_THRESH=3, AE_THRESH=2; walk count 0→5→0.
  - Required: almost_empty=1 for count≤2, almost_full=1 for count≥3, at every step.
- Reset mid-operation.
  - Stimulus: at count=3, pulse rst asynchronously between edges.
  - Required: all outputs take reset values without waiting for clk. A following push of 0x99 then pop returns 0x99.
